// File: rtl/vending_pkg.sv
// Shared state encoding, credit type and default price table for the vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCredit,
        StVend,
        StChange
    } vend_state_e;

    localparam int unsigned CREDIT_W_DEF = 8;
    typedef logic [CREDIT_W_DEF-1:0] credit_t;

    localparam credit_t PRICE_TEA    = 8'd10;
    localparam credit_t PRICE_COKE   = 8'd15;
    localparam credit_t PRICE_COFFEE = 8'd20;
    localparam credit_t PRICE_MILK   = 8'd25;

    localparam int unsigned PROD_TEA    = 0;
    localparam int unsigned PROD_COKE   = 1;
    localparam int unsigned PROD_COFFEE = 2;
    localparam int unsigned PROD_MILK   = 3;

endpackage

// File: rtl/vending_avail_mask.sv
// Per-product affordability: bit i is set when credit covers price i and product i is in stock.
module vending_avail_mask
    import vending_pkg::*;
#(
    parameter int unsigned                     NUM_PROD = 4,
    parameter int unsigned                     CREDIT_W = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0]    PRICES   = '0
) (
    input  logic [CREDIT_W-1:0] credit,
    input  logic [NUM_PROD-1:0] in_stock,
    output logic [NUM_PROD-1:0] avail
);

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            avail[i] = in_stock[i] && (credit >= PRICES[i*CREDIT_W +: CREDIT_W]);
        end
    end

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit, per-product prices, dispense and change handshake.
// Optional per-product stock tracking with sold_out/restock is enabled by VEND_STOCK_EN.
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int unsigned                  NUM_PROD   = 4,
    parameter int unsigned                  CREDIT_W   = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {PRICE_MILK, PRICE_COFFEE,
                                                          PRICE_COKE, PRICE_TEA},
    parameter int unsigned                  STOCK_W    = 4,
    parameter logic [STOCK_W-1:0]           INIT_STOCK = 4'd8,
    localparam int unsigned                 SEL_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_PROD-1:0] avail,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                busy
`ifdef VEND_STOCK_EN
    ,
    output logic [NUM_PROD-1:0] sold_out,
    input  logic                restock
`endif
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_reject_q, sel_reject_d;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] sel_price;
    logic [NUM_PROD-1:0] in_stock;
    logic [SEL_SPAN-1:0] avail_ext;
    logic                sel_ok;

    vending_avail_mask #(
        .NUM_PROD (NUM_PROD),
        .CREDIT_W (CREDIT_W),
        .PRICES   (PRICES)
    ) u_avail_mask (
        .credit   (credit_q),
        .in_stock (in_stock),
        .avail    (avail)
    );

    // Zero-extend so out-of-range indices read as not available.
    assign avail_ext = SEL_SPAN'(avail);
    assign sel_ok    = avail_ext[sel_id];
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        coin_reject_d = 1'b0;
        sel_reject_d  = 1'b0;
        unique case (state_q)
            StIdle, StCredit: begin
                if (state_q == StCredit && cancel) begin
                    state_d       = StChange;
                    coin_reject_d = coin_valid;
                end else if (state_q == StCredit && sel_valid && sel_ok) begin
                    state_d       = StVend;
                    sel_d         = sel_id;
                    coin_reject_d = coin_valid;
                end else begin
                    sel_reject_d = sel_valid;
                    if (coin_valid) begin
                        if (coin_sum[CREDIT_W]) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = (credit_d != '0) ? StCredit : StIdle;
                        end
                    end
                end
            end
            StVend: begin
                coin_reject_d = coin_valid;
                credit_d      = credit_q - sel_price;
                state_d       = (credit_d != '0) ? StChange : StIdle;
            end
            StChange: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            sel_q         <= '0;
            coin_reject_q <= 1'b0;
            sel_reject_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
        end
    end

`ifdef VEND_STOCK_EN
    logic [NUM_PROD-1:0][STOCK_W-1:0] stock_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stock_q <= {NUM_PROD{INIT_STOCK}};
        end else if (restock && !busy) begin
            stock_q <= {NUM_PROD{INIT_STOCK}};
        end else if (dispense_valid) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign in_stock = ~sold_out;
`else
    assign in_stock = '1;
`endif

    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign sel_reject     = sel_reject_q;
    assign dispense_valid = (state_q == StVend);
    assign dispense_id    = sel_q;
    assign change_valid   = (state_q == StChange);
    assign change_amount  = change_valid ? credit_q : '0;
    assign busy           = (state_q == StVend) || (state_q == StChange);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param; dispense/change events are scoreboarded.
module tb_vending_fsm_param;
    import vending_pkg::*;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    credit_t    coin_value;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       change_ready;
    credit_t    credit;
    logic [3:0] avail;
    logic       coin_reject;
    logic       sel_reject;
    logic       dispense_valid;
    logic [1:0] dispense_id;
    logic       change_valid;
    credit_t    change_amount;
    logic       busy;
`ifdef VEND_STOCK_EN
    logic [3:0] sold_out;
    logic       restock;
`endif

    int checks = 0;
    int errors = 0;

    // Expected events: {8'hD1, id} for dispense, {8'hC0, amount} for change.
    logic [15:0] exp_q[$];
    logic        chg_prev;

    vending_fsm_param #(
`ifdef VEND_STOCK_EN
        .INIT_STOCK (4'd1)
`else
        .INIT_STOCK (4'd8)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .sel_valid      (sel_valid),
        .sel_id         (sel_id),
        .cancel         (cancel),
        .change_ready   (change_ready),
        .credit         (credit),
        .avail          (avail),
        .coin_reject    (coin_reject),
        .sel_reject     (sel_reject),
        .dispense_valid (dispense_valid),
        .dispense_id    (dispense_id),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .busy           (busy)
`ifdef VEND_STOCK_EN
        ,
        .sold_out       (sold_out),
        .restock        (restock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        logic [15:0] got;
        logic [15:0] want;
        if (!reset) begin
            chg_prev = 1'b0;
        end else begin
            if (dispense_valid) begin
                got = {8'hD1, 8'(dispense_id)};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dispense_event got %h want none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL dispense_event got %h want %h", got, want);
                    end
                end
            end
            if (change_valid && !chg_prev) begin
                got = {8'hC0, change_amount};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL change_event got %h want none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL change_event got %h want %h", got, want);
                    end
                end
            end
            chg_prev = change_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic coin(input credit_t v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic pay_change();
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
    endtask

    task automatic refill();
`ifdef VEND_STOCK_EN
        restock = 1'b1;
        step();
        restock = 1'b0;
`else
        step();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            coin_valid = i[0];
            coin_value = 8'd10;
            sel_valid  = ~i[0];
            sel_id     = 2'(i);
            cancel     = i[1];
            step();
        end
        checks++;
        if (credit !== 8'd0) begin
            errors++;
            $display("FAIL reset_credit got %0d want 0", credit);
        end
        checks++;
        if ({coin_reject, sel_reject, dispense_valid, change_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {coin_reject, sel_reject, dispense_valid, change_valid, busy});
        end
        checks++;
        if (dispense_id !== 2'd0 || change_amount !== 8'd0 || avail !== 4'b0) begin
            errors++;
            $display("FAIL reset_values got id %0d amt %0d avail %b want 0 0 0000",
                     dispense_id, change_amount, avail);
        end
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        reset      = 1'b1;
        step();
        coin(8'd10);
        checks++;
        if (credit !== 8'd10 || avail !== 4'b0001) begin
            errors++;
            $display("FAIL first_coin got credit %0d avail %b want 10 0001", credit, avail);
        end
        exp_q.push_back({8'hC0, 8'd10});
        do_cancel();
        pay_change();
        checks++;
        if (credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_refund got credit %0d busy %b want 0 0", credit, busy);
        end
    endtask

    task automatic test_exact_purchase();
        refill();
        coin(8'd5);
        coin(8'd5);
        coin(8'd10);
        checks++;
        if (credit !== 8'd20 || avail !== 4'b0111) begin
            errors++;
            $display("FAIL exact_credit got credit %0d avail %b want 20 0111", credit, avail);
        end
        exp_q.push_back({8'hD1, 8'(PROD_COFFEE)});
        select(2'(PROD_COFFEE));
        checks++;
        if (dispense_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend got dv %b busy %b want 1 1", dispense_valid, busy);
        end
        step();
        checks++;
        if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0 || dispense_valid !== 1'b0) begin
            errors++;
            $display("FAIL exact_after got credit %0d cv %b busy %b dv %b want 0 0 0 0",
                     credit, change_valid, busy, dispense_valid);
        end
    endtask

    task automatic test_change_handshake();
        refill();
        coin(8'd10);
        coin(8'd10);
        coin(8'd10);
        exp_q.push_back({8'hD1, 8'(PROD_COKE)});
        exp_q.push_back({8'hC0, 8'd15});
        select(2'(PROD_COKE));
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (change_valid !== 1'b1 || change_amount !== 8'd15) begin
                errors++;
                $display("FAIL change_hold cycle %0d got cv %b amt %0d want 1 15",
                         i, change_valid, change_amount);
            end
            if (i < 2) step();
        end
        pay_change();
        checks++;
        if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL change_done got cv %b credit %0d busy %b want 0 0 0",
                     change_valid, credit, busy);
        end
    endtask

    task automatic test_rejects();
        refill();
        coin(8'd0);
        checks++;
        if (credit !== 8'd0 || coin_reject !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_coin got credit %0d rej %b busy %b want 0 0 0",
                     credit, coin_reject, busy);
        end
        select(2'd0);
        checks++;
        if (sel_reject !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_select got rej %b busy %b want 1 0", sel_reject, busy);
        end
        coin(8'd100);
        coin(8'd100);
        coin(8'd50);
        coin(8'd10);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd250) begin
            errors++;
            $display("FAIL overflow got rej %b credit %0d want 1 250", coin_reject, credit);
        end
        step();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse got %b want 0", coin_reject);
        end
        exp_q.push_back({8'hC0, 8'd250});
        do_cancel();
        pay_change();
        coin(8'd20);
        select(2'(PROD_MILK));
        checks++;
        if (sel_reject !== 1'b1 || busy !== 1'b0 || credit !== 8'd20) begin
            errors++;
            $display("FAIL price_reject got rej %b busy %b credit %0d want 1 0 20",
                     sel_reject, busy, credit);
        end
        exp_q.push_back({8'hD1, 8'(PROD_COFFEE)});
        coin_valid = 1'b1;
        coin_value = 8'd5;
        sel_valid  = 1'b1;
        sel_id     = 2'(PROD_COFFEE);
        step();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        checks++;
        if (coin_reject !== 1'b1 || busy !== 1'b1 || sel_reject !== 1'b0) begin
            errors++;
            $display("FAIL coin_with_sel got rej %b busy %b srej %b want 1 1 0",
                     coin_reject, busy, sel_reject);
        end
        step();
        checks++;
        if (credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coin_with_sel_after got credit %0d busy %b want 0 0", credit, busy);
        end
    endtask

    task automatic test_cancel();
        refill();
        coin(8'd25);
        coin(8'd10);
        exp_q.push_back({8'hC0, 8'd35});
        do_cancel();
        checks++;
        if (change_valid !== 1'b1 || change_amount !== 8'd35 || dispense_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_refund got cv %b amt %0d dv %b want 1 35 0",
                     change_valid, change_amount, dispense_valid);
        end
        pay_change();
        do_cancel();
        checks++;
        if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_cancel got cv %b credit %0d busy %b want 0 0 0",
                     change_valid, credit, busy);
        end
    endtask

`ifdef VEND_STOCK_EN
    task automatic test_stock();
        refill();
        checks++;
        if (sold_out !== 4'b0) begin
            errors++;
            $display("FAIL stock_init got %b want 0000", sold_out);
        end
        coin(8'd10);
        exp_q.push_back({8'hD1, 8'(PROD_TEA)});
        select(2'(PROD_TEA));
        step();
        checks++;
        if (sold_out !== 4'b0001) begin
            errors++;
            $display("FAIL stock_sold got %b want 0001", sold_out);
        end
        coin(8'd10);
        select(2'(PROD_TEA));
        checks++;
        if (sel_reject !== 1'b1 || avail !== 4'b0000) begin
            errors++;
            $display("FAIL stock_reject got rej %b avail %b want 1 0000", sel_reject, avail);
        end
        refill();
        checks++;
        if (sold_out !== 4'b0 || avail !== 4'b0001) begin
            errors++;
            $display("FAIL restock got sold %b avail %b want 0000 0001", sold_out, avail);
        end
        exp_q.push_back({8'hD1, 8'(PROD_TEA)});
        select(2'(PROD_TEA));
        step();
        checks++;
        if (credit !== 8'd0 || sold_out !== 4'b0001) begin
            errors++;
            $display("FAIL stock_rebuy got credit %0d sold %b want 0 0001", credit, sold_out);
        end
    endtask
`endif

    initial begin
        reset        = 1'b0;
        coin_valid   = 1'b0;
        coin_value   = '0;
        sel_valid    = 1'b0;
        sel_id       = '0;
        cancel       = 1'b0;
        change_ready = 1'b0;
`ifdef VEND_STOCK_EN
        restock      = 1'b0;
`endif
        test_reset();
`ifdef VEND_STOCK_EN
        test_stock();
`endif
        test_exact_purchase();
        test_change_handshake();
        test_rejects();
        test_cancel();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
